// File: rtl/trellis_bank_sched_if.sv
// Trellis bank scheduler bus: decode enable and survivor vector in,
// bank strobes, addresses, frame pulse and traceback enables out.
// Optional display ports exist only with TRELLIS_DISP_CTRL_EN.
interface trellis_bank_sched_if #(
    parameter int AW = 10,
    parameter int SW = 8
);
    logic          enable;
    logic [SW-1:0] sel_in;
    logic [SW-1:0] wr_data;
    logic [3:0]    wr_bank_oh;
    logic [3:0]    rd_bank_oh;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [1:0]    bank_idx;
    logic          frame_done;
    logic [1:0]    tb_en;
`ifdef TRELLIS_DISP_CTRL_EN
    logic [AW-1:0] disp_wr_addr;
    logic [AW-1:0] disp_rd_addr;
    logic          disp_sel;
`endif

    modport master (
        output enable, sel_in,
        input  wr_data, wr_bank_oh, rd_bank_oh,
        input  wr_addr, rd_addr, bank_idx,
        input  frame_done, tb_en
`ifdef TRELLIS_DISP_CTRL_EN
        ,
        input  disp_wr_addr, disp_rd_addr, disp_sel
`endif
    );

    modport slave (
        input  enable, sel_in,
        output wr_data, wr_bank_oh, rd_bank_oh,
        output wr_addr, rd_addr, bank_idx,
        output frame_done, tb_en
`ifdef TRELLIS_DISP_CTRL_EN
        ,
        output disp_wr_addr, disp_rd_addr, disp_sel
`endif
    );
endinterface

// File: rtl/trellis_bank_sched.sv
// Four-bank trellis memory scheduler: one bank written per frame, the two
// neighbours read for traceback, the opposite bank idle.
// Ports: clk, rst (async, active-high), bus (trellis_bank_sched_if.slave).
// Macro TRELLIS_DISP_CTRL_EN adds display-buffer ping-pong control.
module trellis_bank_sched #(
    parameter int AW = 10,
    parameter int SW = 8
) (
    input  logic clk,
    input  logic rst,
    trellis_bank_sched_if.slave bus
);
    localparam logic [AW-1:0] CNT_MAX = '1;

    function automatic logic [3:0] oh(input logic [1:0] b);
        oh = 4'b0001 << b;
    endfunction

    logic [AW-1:0] wr_cnt;
    logic [1:0]    bank_q;
    logic [1:0]    tb_q;
    logic [SW-1:0] data_q;
    logic [AW-1:0] waddr_q;
    logic [AW-1:0] raddr_q;
    logic [3:0]    woh_q;
    logic [3:0]    roh_q;
    logic          done_q;

    logic          wrap;
    logic [1:0]    bank_nxt;
    logic [1:0]    bank_rd1;
    logic [1:0]    bank_rd3;

    assign wrap     = (wr_cnt == CNT_MAX);
    assign bank_nxt = bank_q + 2'd1;
    assign bank_rd1 = bank_q + 2'd1;
    assign bank_rd3 = bank_q + 2'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            bank_q  <= 2'd0;
            tb_q    <= 2'd0;
            data_q  <= '0;
            waddr_q <= '0;
            raddr_q <= '1;
            woh_q   <= 4'd0;
            roh_q   <= 4'd0;
            done_q  <= 1'b0;
        end else if (!bus.enable) begin
            // restart; wr_data and addresses hold
            wr_cnt <= '0;
            bank_q <= 2'd0;
            tb_q   <= 2'd0;
            woh_q  <= 4'd0;
            roh_q  <= 4'd0;
            done_q <= 1'b0;
        end else begin
            wr_cnt  <= wr_cnt + 1'b1;
            data_q  <= bus.sel_in;
            waddr_q <= wr_cnt;
            raddr_q <= ~wr_cnt;
            woh_q   <= oh(bank_q);
            roh_q   <= oh(bank_rd1) | oh(bank_rd3);
            done_q  <= wrap;
            if (wrap) begin
                bank_q <= bank_nxt;
                // traceback units start once enough history exists
                if (bank_nxt == 2'd2) tb_q[0] <= 1'b1;
                if (bank_nxt == 2'd3) tb_q[1] <= 1'b1;
            end
        end
    end

    assign bus.wr_data    = data_q;
    assign bus.wr_addr    = waddr_q;
    assign bus.rd_addr    = raddr_q;
    assign bus.wr_bank_oh = woh_q;
    assign bus.rd_bank_oh = roh_q;
    assign bus.bank_idx   = bank_q;
    assign bus.frame_done = done_q;
    assign bus.tb_en      = tb_q;

`ifdef TRELLIS_DISP_CTRL_EN
    localparam logic [AW-1:0] DWR0 = AW'(2);
    localparam logic [AW-1:0] DRD0 = CNT_MAX - AW'(2);

    logic [AW-1:0] dwr_q;
    logic [AW-1:0] drd_q;
    logic [4:0]    dsel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwr_q  <= DWR0;
            drd_q  <= DRD0;
            dsel_q <= 5'd0;
        end else begin
            // free-running 5-cycle delay of bank parity
            dsel_q <= {dsel_q[3:0], bank_q[0]};
            if (!bus.enable) begin
                dwr_q <= DWR0;
                drd_q <= DRD0;
            end else begin
                dwr_q <= dwr_q - 1'b1;
                drd_q <= drd_q + 1'b1;
            end
        end
    end

    assign bus.disp_wr_addr = dwr_q;
    assign bus.disp_rd_addr = drd_q;
    assign bus.disp_sel     = dsel_q[4];
`endif
endmodule

// File: tb/tb_trellis_bank_sched.sv
// Bench for trellis_bank_sched (AW=4, SW=8): frame-level model plus
// directed literal checks of sequences, wraps, restart and async reset.
module tb_trellis_bank_sched;
    localparam int AW = 4;
    localparam int SW = 8;
    localparam int FL = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trellis_bank_sched_if #(.AW(AW), .SW(SW)) bus ();

    trellis_bank_sched #(.AW(AW), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // model: k = enabled edges since last restart/reset
    int k = 0;
    bit act = 1'b0;
    int m_data = 0;
    int m_waddr = 0;
    int m_raddr = FL - 1;
    int hist [5] = '{default: 0};

    function automatic int bank_of(input int n);
        return (n / FL) % 4;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0; act = 0; m_data = 0;
            m_waddr = 0; m_raddr = FL - 1;
            hist = '{default: 0};
        end else begin
            for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = bank_of(k) % 2;
            if (bus.enable) begin
                m_data = int'(bus.sel_in);
                m_waddr = k % FL;
                m_raddr = FL - 1 - (k % FL);
                act = 1; k++;
            end else begin
                act = 0; k = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            int b;
            int ewoh;
            int eroh;
            b = act ? bank_of(k - 1) : 0;
            ewoh = act ? (1 << b) : 0;
            eroh = act ? ((1 << ((b+1)%4)) | (1 << ((b+3)%4))) : 0;
            chk("wr_data", int'(bus.wr_data), m_data);
            chk("wr_addr", int'(bus.wr_addr), m_waddr);
            chk("rd_addr", int'(bus.rd_addr), m_raddr);
            chk("wr_oh", int'(bus.wr_bank_oh), ewoh);
            chk("rd_oh", int'(bus.rd_bank_oh), eroh);
            chk("bank", int'(bus.bank_idx), bank_of(k));
            chk("done", int'(bus.frame_done),
                (act && (k % FL == 0)) ? 1 : 0);
            chk("tb_en", int'(bus.tb_en),
                (k >= 3*FL ? 2 : 0) + (k >= 2*FL ? 1 : 0));
            chk("overlap", int'(bus.wr_bank_oh & bus.rd_bank_oh), 0);
`ifdef TRELLIS_DISP_CTRL_EN
            chk("dwr", int'(bus.disp_wr_addr), (2 - k) & (FL-1));
            chk("drd", int'(bus.disp_rd_addr), (13 + k) & (FL-1));
            chk("dsel", int'(bus.disp_sel), hist[4]);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
        bus.sel_in = SW'($urandom);
    endtask

    int e;

    initial begin
        bus.enable = 1'b0;
        bus.sel_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_rd_addr", int'(bus.rd_addr), 15);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_woh", int'(bus.wr_bank_oh), 0);
        chk("rst_tb_en", int'(bus.tb_en), 0);
`ifdef TRELLIS_DISP_CTRL_EN
        chk("rst_dwr", int'(bus.disp_wr_addr), 2);
        chk("rst_drd", int'(bus.disp_rd_addr), 13);
`endif
        chk_on = 1'b1;
        rst = 1'b0;
        bus.enable = 1'b1;
        e = 0;
        for (int i = 0; i < 16; i++) begin
            step(); e++;
            chk("seq_wa", int'(bus.wr_addr), i);
            chk("seq_ra", int'(bus.rd_addr), 15 - i);
            chk("seq_woh", int'(bus.wr_bank_oh), 4'b0001);
            chk("seq_roh", int'(bus.rd_bank_oh), 4'b1010);
`ifdef TRELLIS_DISP_CTRL_EN
            if (i == 2) begin
                chk("dwr_wrap", int'(bus.disp_wr_addr), 15);
                chk("drd_wrap", int'(bus.disp_rd_addr), 0);
            end
`endif
        end
        chk("done16", int'(bus.frame_done), 1);
        chk("bank16", int'(bus.bank_idx), 1);
        while (e < 66) begin
            step(); e++;
            if (e == 17) begin
                chk("done17", int'(bus.frame_done), 0);
                chk("woh17", int'(bus.wr_bank_oh), 4'b0010);
                chk("roh17", int'(bus.rd_bank_oh), 4'b0101);
            end
            if (e == 32) begin
                chk("bank32", int'(bus.bank_idx), 2);
                chk("tb32", int'(bus.tb_en), 1);
            end
            if (e == 48) chk("tb48", int'(bus.tb_en), 3);
            if (e == 64) begin
                chk("bank64", int'(bus.bank_idx), 0);
                chk("tb64", int'(bus.tb_en), 3);
                chk("done64", int'(bus.frame_done), 1);
            end
        end

        bus.enable = 1'b0;
        step();
        bus.enable = 1'b1;
        repeat (31) step();
        chk("pre_bank", int'(bus.bank_idx), 1);
        chk("pre_wa", int'(bus.wr_addr), 14);
        bus.enable = 1'b0;
        step();
        chk("drop_done", int'(bus.frame_done), 0);
        chk("drop_bank", int'(bus.bank_idx), 0);
        chk("drop_tb", int'(bus.tb_en), 0);
        chk("drop_woh", int'(bus.wr_bank_oh), 0);
        repeat (2) step();

        bus.enable = 1'b1;
        repeat (20) step();
        #2 rst = 1'b1;
        #1;
        chk("ar_woh", int'(bus.wr_bank_oh), 0);
        chk("ar_roh", int'(bus.rd_bank_oh), 0);
        chk("ar_ra", int'(bus.rd_addr), 15);
        chk("ar_wa", int'(bus.wr_addr), 0);
        chk("ar_data", int'(bus.wr_data), 0);
        chk("ar_bank", int'(bus.bank_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.sel_in = 8'hA5;
        @(negedge clk);
        chk("a5_data", int'(bus.wr_data), 8'hA5);
        chk("a5_wa", int'(bus.wr_addr), 0);
        chk("a5_woh", int'(bus.wr_bank_oh), 4'b0001);
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/trellis_bank_sched.md
TRELLIS_BANK_SCHED -- requirements
Module: trellis_bank_sched

Interface
REQ-001 Parameter: AW, default 10, trellis memory address width; frame length is 2^AW cycles.
REQ-002 Parameter: SW, default 8, survivor-selection vector width (one bit per ACS state).
REQ-003 Clocking and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-004 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: enable  in  1  decode active; low causes a synchronous restart.
REQ-007 Port: sel_in  in  SW  survivor-selection vector from the ACS array.
REQ-008 Port: wr_data  out  SW  registered sel_in, broadcast to all four trellis banks.
REQ-009 Port: wr_bank_oh  out  4  one-hot write strobe for banks A..D (bit0=A).
REQ-010 Port: rd_bank_oh  out  4  banks currently presented with rd_addr.
REQ-011 Port: wr_addr  out  AW  write address.
REQ-012 Port: rd_addr  out  AW  traceback read address.
REQ-013 Port: bank_idx  out  2  current write bank index.
REQ-014 Port: frame_done  out  1  one-cycle pulse at each frame boundary.
REQ-015 Port: tb_en  out  2  sticky traceback-unit enables (bit0=TBU0, bit1=TBU1).

Function
REQ-016 wr_cnt SHALL increment by 1 per cycle while enable=1, wrapping from 2^AW-1 to 0.
REQ-017 rd_cnt SHALL equal the bitwise inverse of wr_cnt: all-ones at frame start, counting down.
REQ-018 On a cycle with enable=1, the outputs SHALL register as follows (one-cycle latency from the wr_cnt/sel_in sample): wr_data<=sel_in; wr_addr<=wr_cnt; rd_addr<=rd_cnt.
REQ-019 On the same enabled cycle, wr_bank_oh<=1<<bank_idx and rd_bank_oh<=(1<<(bank_idx+1 mod 4))|(1<<(bank_idx+3 mod 4)).
REQ-020 The bank at (bank_idx+2) mod 4 is idle; its bit SHALL be 0 in both one-hot outputs.
REQ-021 When wr_cnt=2^AW-1 and enable=1, bank_idx SHALL advance by 1 mod 4 on that edge, and frame_done SHALL be 1 for exactly the following cycle.
REQ-022 tb_en[0] SHALL set on the edge where bank_idx becomes 2; tb_en[1] SHALL set on the edge where bank_idx becomes 3.
REQ-023 Both tb_en bits SHALL hold until rst or enable=0.
REQ-024 When enable=0, the block SHALL synchronously set wr_cnt=0, bank_idx=0 and tb_en=0, with wr_bank_oh=0, rd_bank_oh=0 and frame_done=0.
REQ-025 wr_data SHALL hold while enable=0.
REQ-026 If enable falls on the wrap cycle, the restart SHALL take priority: bank_idx=0 and no frame_done pulse.
REQ-027 wr_bank_oh and rd_bank_oh SHALL never overlap, and wr_bank_oh SHALL never have more than one bit set.

Reset
REQ-028 While rst=1, the block SHALL drive every output to 0 except rd_addr, which SHALL be all-ones; wr_cnt=0 and bank_idx=0.
REQ-029 When rst deasserts mid-frame, the block SHALL restart at frame 0 bank A on the first enabled edge.

Configuration
REQ-030 Macro: TRELLIS_DISP_CTRL_EN adds display-buffer ping-pong control.
REQ-031 When TRELLIS_DISP_CTRL_EN is defined, the block SHALL add these output ports: disp_wr_addr (AW), disp_rd_addr (AW), disp_sel (1).
REQ-032 disp_wr_addr SHALL reset and restart to 2, decrementing each enabled cycle; disp_rd_addr SHALL reset and restart to 2^AW-3, incrementing each enabled cycle.
REQ-033 disp_sel SHALL equal bank_idx[0] delayed 5 cycles; its reset value is 0.
REQ-034 When TRELLIS_DISP_CTRL_EN is undefined, those ports and their logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-035 Bench SHALL cover: AW=4, rst pulse then enable=1 held -> wr_addr 0..15, rd_addr 15..0, wr_bank_oh=0001, rd_bank_oh=1010.
REQ-036 Bench SHALL cover: AW=4, run 64 cycles -> bank_idx sequence 0,1,2,3,0; frame_done pulses at cycles 17,33,49,65; rd_bank_oh 1010,0101,1010,0101.
REQ-037 Bench SHALL cover: AW=4, continuous run -> tb_en=01 after 2nd wrap, 11 after 3rd, stays 11 through wrap back to bank 0.
REQ-038 Bench SHALL cover: enable dropped at wr_cnt=15 of bank 1 -> no frame_done, bank_idx=0, tb_en=00, wr_bank_oh=0000 next cycle.
REQ-039 Bench SHALL cover: rst asserted asynchronously mid-frame (between edges) -> outputs zero immediately, rd_addr=all-ones; sel_in=8'hA5 on first enabled cycle appears on wr_data one cycle later.
REQ-040 Bench SHALL cover: with TRELLIS_DISP_CTRL_EN, AW=4 -> disp_wr_addr 2,1,0,15,...; disp_rd_addr 13,14,15,0,...; disp_sel toggles 5 cycles after each bank_idx[0] change.
